// File: rtl/mem_frame_arbiter.sv
// Round-robin frame arbiter: merges three framed word streams into one memory write port.
// Optional stalled-frame abort is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_frame_arbiter #(
  parameter int unsigned pTIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [2:0]  i_valid,
  output logic [2:0]  o_ready,
  input  logic [31:0] i_data_port1,
  input  logic [31:0] i_data_port2,
  input  logic [31:0] i_data_port3,
  input  logic [1:0]  i_info_port1,
  input  logic [1:0]  i_info_port2,
  input  logic [1:0]  i_info_port3,
  input  logic [1:0]  i_extra_byte1,
  input  logic [1:0]  i_extra_byte2,
  input  logic [1:0]  i_extra_byte3,
  input  logic        i_mem_full,
  output logic [31:0] o_data,
  output logic [1:0]  o_port_num,
  output logic        o_en_mem,
  output logic [1:0]  o_info_port,
  output logic [1:0]  o_extra_byte,
  output logic [7:0]  o_drop_cnt,
  output logic        o_busy
);

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  state_e      state_q, state_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  grant_q, grant_d;
  logic        en_q, en_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  port_q, port_d;
  logic [1:0]  info_q, info_d;
  logic [1:0]  xb_q, xb_d;
  logic [7:0]  drop_q, drop_d;
  logic [8:0]  drop_sum;

  logic [2:0]  start_bits, cand, drop_req;
  logic [1:0]  win;
  logic [31:0] g_data;
  logic [1:0]  g_info, g_xb;
  logic        g_valid;
  logic        xfer;
  logic        tmo_fire;

  assign start_bits = {i_info_port3[0], i_info_port2[0], i_info_port1[0]};
  assign cand       = i_valid & start_bits;
  assign drop_req   = i_valid & ~start_bits;

  // First requesting port after the last frame's owner, order 0,1,2,0.
  always_comb begin
    win = 2'd0;
    unique case (last_q)
      2'd0:    win = cand[1] ? 2'd1 : (cand[2] ? 2'd2 : 2'd0);
      2'd1:    win = cand[2] ? 2'd2 : (cand[0] ? 2'd0 : 2'd1);
      default: win = cand[0] ? 2'd0 : (cand[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    g_info  = '0;
    g_xb    = '0;
    unique case (grant_q)
      2'd0: begin
        g_valid = i_valid[0];
        g_data  = i_data_port1;
        g_info  = i_info_port1;
        g_xb    = i_extra_byte1;
      end
      2'd1: begin
        g_valid = i_valid[1];
        g_data  = i_data_port2;
        g_info  = i_info_port2;
        g_xb    = i_extra_byte2;
      end
      default: begin
        g_valid = i_valid[2];
        g_data  = i_data_port3;
        g_info  = i_info_port3;
        g_xb    = i_extra_byte3;
      end
    endcase
  end

  assign xfer = (state_q == StXfer) && g_valid && !i_mem_full;

  always_comb begin
    o_ready = 3'b000;
    if (i_reset) begin
      if (state_q == StIdle) begin
        o_ready = drop_req;
      end else begin
        unique case (grant_q)
          2'd0:    o_ready = {2'b00, ~i_mem_full};
          2'd1:    o_ready = {1'b0, ~i_mem_full, 1'b0};
          default: o_ready = {~i_mem_full, 2'b00};
        endcase
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TmoW = (pTIMEOUT > 1) ? $clog2(pTIMEOUT + 1) : 1;

  logic [TmoW-1:0] tmo_q, tmo_d;

  // Only starved cycles count; backpressure is not the source port's fault.
  always_comb begin
    tmo_d    = tmo_q;
    tmo_fire = 1'b0;
    if ((state_q != StXfer) || xfer) begin
      tmo_d = '0;
    end else if (!g_valid && !i_mem_full) begin
      if (tmo_q == TmoW'(pTIMEOUT - 1)) begin
        tmo_fire = 1'b1;
        tmo_d    = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    en_d     = 1'b0;
    data_d   = data_q;
    port_d   = port_q;
    info_d   = info_q;
    xb_d     = xb_q;
    drop_sum = {1'b0, drop_q};
    unique case (state_q)
      StIdle: begin
        drop_sum = {1'b0, drop_q} + 9'(drop_req[0]) + 9'(drop_req[1]) + 9'(drop_req[2]);
        if (|cand) begin
          grant_d = win;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (xfer) begin
          en_d   = 1'b1;
          data_d = g_data;
          info_d = g_info;
          xb_d   = g_xb;
          port_d = grant_q;
          if (g_info[1]) begin
            state_d = StIdle;
            last_d  = grant_q;
          end
        end else if (tmo_fire) begin
          // Close the stalled frame with a synthetic end marker.
          en_d     = 1'b1;
          data_d   = '0;
          info_d   = 2'b10;
          xb_d     = '0;
          port_d   = grant_q;
          drop_sum = {1'b0, drop_q} + 9'd1;
          state_d  = StIdle;
          last_d   = grant_q;
        end
      end
      default: state_d = StIdle;
    endcase
    drop_d = (drop_sum > 9'd255) ? 8'hff : drop_sum[7:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= StIdle;
      last_q  <= 2'd2;
      grant_q <= 2'd0;
      en_q    <= 1'b0;
      data_q  <= '0;
      port_q  <= '0;
      info_q  <= '0;
      xb_q    <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      en_q    <= en_d;
      data_q  <= data_d;
      port_q  <= port_d;
      info_q  <= info_d;
      xb_q    <= xb_d;
      drop_q  <= drop_d;
    end
  end

  assign o_en_mem     = en_q;
  assign o_data       = data_q;
  assign o_port_num   = port_q;
  assign o_info_port  = info_q;
  assign o_extra_byte = xb_q;
  assign o_drop_cnt   = drop_q;
  assign o_busy       = (state_q == StXfer);

endmodule
